// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field widths, exponent limits, the canonical
// NaN, operand classes and the divider FSM state encoding.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] CANON_NAN_DEF = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORM,
        ROUND,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 unpack: sign, biased exponent, mantissa with hidden
// bit and operand class. Ports: bits in; sign/expo/mant/cls out.
// Subnormals are classed as ZERO (denormals-are-zero).
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0]       bits,
    output logic              sign,
    output logic [EXP_W-1:0]  expo,
    output logic [MANT_W-1:0] mant,
    output fp_class_t         cls
);

    logic [FRAC_W-1:0] frac;

    assign sign = bits[31];
    assign expo = bits[30:23];
    assign frac = bits[22:0];

    always_comb begin
        cls  = NORMAL;
        mant = {1'b1, frac};
        if (expo == '0) begin
            cls  = ZERO;
            mant = '0;
        end else if (expo == '1) begin
            cls  = (frac != '0) ? NAN : INF;
            mant = '0;
        end
    end

endmodule

// File: rtl/fp_div_driver.sv
// Iterative FP32 divider z = a / b, radix-2 restoring, start/busy/done.
// Ports: clk, rst, start, a_bits, b_bits in; busy, done, z_bits out.
module fp_div_driver
    import fp32_pkg::*;
#(
    parameter int          QBITS     = 26,
    parameter logic [31:0] CANON_NAN = CANON_NAN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_bits,
    input  logic [31:0] b_bits,
    output logic        busy,
    output logic        done,
    output logic [31:0] z_bits
);

    localparam logic [4:0] CNT_LAST = 5'(QBITS - 1);

    state_t state, state_n;

    logic [31:0]        op_a, op_b;
    logic [4:0]         cnt;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [MANT_W-1:0]  mb_r;
    logic [MANT_W:0]    rem_r;
    logic [QBITS-1:0]   q_r;
    logic [31:0]        res_r;

    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MANT_W-1:0]  ma, mb;
    fp_class_t          ca, cb;

    fp32_classify u_cls_a (
        .bits (op_a),
        .sign (sa),
        .expo (ea),
        .mant (ma),
        .cls  (ca)
    );

    fp32_classify u_cls_b (
        .bits (op_b),
        .sign (sb),
        .expo (eb),
        .mant (mb),
        .cls  (cb)
    );

    // Special-operand result, in priority order.
    logic        special;
    logic [31:0] spec_res;
    logic        sgn;

    always_comb begin
        sgn      = sa ^ sb;
        special  = 1'b1;
        spec_res = '0;
        if (ca == NAN || cb == NAN ||
            (ca == ZERO && cb == ZERO) ||
            (ca == INF && cb == INF)) begin
            spec_res = CANON_NAN;
        end else if (cb == ZERO || ca == INF) begin
            spec_res = {sgn, 8'hFF, 23'd0};
        end else if (ca == ZERO || cb == INF) begin
            spec_res = {sgn, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // One restoring step: subtract divisor when it fits.
    logic [MANT_W+1:0] diff;
    logic              ge;
    logic [MANT_W:0]   rem_nx;

    always_comb begin
        diff   = {1'b0, rem_r} - {2'b00, mb_r};
        ge     = ~diff[MANT_W+1];
        rem_nx = ge ? diff[MANT_W:0] : rem_r;
    end

    // Round to nearest even. After a normalising shift the round bit is
    // zero and the lost bit lives in the remainder, so G with R|S|lsb
    // still decides correctly.
    logic [MANT_W-1:0]  mant;
    logic               g_bit, st_bit, up;
    logic [MANT_W:0]    sum;
    logic signed [9:0]  exp_rd;
    logic [31:0]        rnd_res;

    always_comb begin
        mant   = q_r[QBITS-1 -: MANT_W];
        g_bit  = q_r[QBITS-MANT_W-1];
        st_bit = (rem_r != '0) | (|q_r[QBITS-MANT_W-2:0]);
        up     = g_bit & (st_bit | mant[0]);
        sum    = {1'b0, mant} + {{MANT_W{1'b0}}, up};
        exp_rd = sum[MANT_W] ? exp_r + 10'sd1 : exp_r;
        if (exp_rd >= 10'(EXP_MAX)) begin
            rnd_res = {sign_r, 8'hFF, 23'd0};
        end else if (exp_rd <= 10'sd0) begin
            rnd_res = {sign_r, 31'd0};
        end else if (sum[MANT_W]) begin
            rnd_res = {sign_r, exp_rd[7:0], sum[MANT_W-1:1]};
        end else begin
            rnd_res = {sign_r, exp_rd[7:0], sum[FRAC_W-1:0]};
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = UNPACK;
            UNPACK:  state_n = special ? FINISH : DIVIDE;
            DIVIDE:  if (cnt == CNT_LAST) state_n = NORM;
            NORM:    state_n = ROUND;
            ROUND:   state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            z_bits <= '0;
            op_a   <= '0;
            op_b   <= '0;
            cnt    <= '0;
            sign_r <= 1'b0;
            exp_r  <= '0;
            mb_r   <= '0;
            rem_r  <= '0;
            q_r    <= '0;
            res_r  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a <= a_bits;
                        op_b <= b_bits;
                        busy <= 1'b1;
                    end
                end
                UNPACK: begin
                    sign_r <= sgn;
                    exp_r  <= $signed({2'b00, ea}) - $signed({2'b00, eb})
                              + 10'(EXP_BIAS);
                    mb_r   <= mb;
                    rem_r  <= {1'b0, ma};
                    q_r    <= '0;
                    cnt    <= '0;
                    res_r  <= spec_res;
                end
                DIVIDE: begin
                    q_r   <= {q_r[QBITS-2:0], ge};
                    rem_r <= {rem_nx[MANT_W-1:0], 1'b0};
                    cnt   <= cnt + 5'd1;
                end
                NORM: begin
                    if (!q_r[QBITS-1]) begin
                        q_r   <= {q_r[QBITS-2:0], 1'b0};
                        exp_r <= exp_r - 10'sd1;
                    end
                end
                ROUND: begin
                    res_r <= rnd_res;
                end
                FINISH: begin
                    z_bits <= res_r;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_driver.sv
// Directed self-checking bench for fp_div_driver: arithmetic, specials,
// range limits, handshake corner cases and asynchronous reset.
module tb_fp_div_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_bits;
    logic [31:0] b_bits;
    logic        busy;
    logic        done;
    logic [31:0] z_bits;

    int total = 0;
    int bad   = 0;

    fp_div_driver dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_bits (a_bits),
        .b_bits (b_bits),
        .busy   (busy),
        .done   (done),
        .z_bits (z_bits)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for done, sampling 1 time unit after each edge; n = edges.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] z, input int lat,
                         input string tag);
        int n;
        @(negedge clk);
        start  = 1'b1;
        a_bits = a;
        b_bits = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk(32'(busy), 32'd1, {tag, "_busy"});
        wait_done(n);
        chk(32'(n), 32'(lat), {tag, "_lat"});
        chk(z_bits, z, {tag, "_z"});
        chk(32'(busy), 32'd0, {tag, "_busy_done"});
        @(posedge clk);
        #1;
        chk(32'(done), 32'd0, {tag, "_pulse"});
    endtask

    initial begin
        int n;
        int dcount;
        rst    = 1'b1;
        start  = 1'b0;
        a_bits = '0;
        b_bits = '0;
        repeat (2) @(posedge clk);
        #1;
        chk(32'(busy), 32'd0, "rst_busy");
        chk(32'(done), 32'd0, "rst_done");
        chk(z_bits, 32'd0, "rst_z");
        @(negedge clk);
        rst = 1'b0;

        do_op(32'h40C00000, 32'h40000000, 32'h40400000, 30, "six_by_two");
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 30, "third");
        do_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 30, "neg");
        do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 2, "x_div_0");
        do_op(32'h00000000, 32'h00000000, 32'h7FC00000, 2, "zero_zero");
        do_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 2, "inf_inf");
        do_op(32'h3F800000, 32'h7F800000, 32'h00000000, 2, "x_div_inf");
        do_op(32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 30, "overflow");
        do_op(32'h00800000, 32'h4B000000, 32'h00000000, 30, "underflow");
        do_op(32'h00400000, 32'h3F800000, 32'h00000000, 2, "daz");

        // Start held high with other operands while busy.
        @(negedge clk);
        start  = 1'b1;
        a_bits = 32'h3F800000;
        b_bits = 32'h40800000;
        @(posedge clk);
        #1;
        a_bits = 32'h40C00000;
        b_bits = 32'h40000000;
        wait_done(n);
        start = 1'b0;
        chk(32'(n), 32'd30, "hold_lat");
        chk(z_bits, 32'h3E800000, "hold_z");
        @(posedge clk);
        #1;
        chk(32'(busy), 32'd0, "hold_no_accept");

        // Back-to-back: start in the done cycle.
        do_op(32'h3F800000, 32'h40800000, 32'h3E800000, 30, "b2b_first");
        @(negedge clk);
        start  = 1'b1;
        a_bits = 32'h3F800000;
        b_bits = 32'h40800000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        start  = 1'b1;
        a_bits = 32'h40C00000;
        b_bits = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk(32'(busy), 32'd1, "b2b_accept");
        wait_done(n);
        chk(32'(n), 32'd30, "b2b_lat");
        chk(z_bits, 32'h40400000, "b2b_z");

        // Reset in the middle of a divide.
        @(negedge clk);
        start  = 1'b1;
        a_bits = 32'h3F800000;
        b_bits = 32'h40400000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk(32'(busy), 32'd0, "mid_rst_busy");
        chk(32'(done), 32'd0, "mid_rst_done");
        chk(z_bits, 32'd0, "mid_rst_z");
        @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
        end
        chk(32'(dcount), 32'd0, "mid_rst_no_done");
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 30, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
